// File: rtl/ch_est_sched.sv
// ch_est_sched: NB-IoT subframe scheduler launching one channel-estimation run per data subframe.
// Optional watchdog on WAIT_RDY/RUN enabled by CH_EST_SCHED_TIMEOUT_EN.
module ch_est_sched #(
  parameter int TIMEOUT_W   = 12,
  parameter int TIMEOUT_CYC = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sf_start,
  input  logic       sfn_lsb,
  input  logic [2:0] v_shift,
  input  logic       demap_ready,
  input  logic       nrs_gen_ready,
  input  logic       core_done,
  input  logic       err_clr,
  output logic       core_start,
  output logic [2:0] core_v_shift,
  output logic       est_ack_demap,
  output logic       est_ack_nrs,
  output logic [3:0] sf_idx,
  output logic       sf_skip,
  output logic       busy,
  output logic       err_overrun,
  output logic       err_timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_RDY, RUN, ACK} state_t;
  state_t     state;
  logic       demap_flag, nrs_flag, dem_ok, nrs_ok, skip, tmo;
  logic [3:0] nidx;
  always_comb begin
    nidx   = sf_idx == 4'd9 ? 4'd0 : sf_idx + 4'd1;
    skip   = nidx == 4'd0 || nidx == 4'd5 || (nidx == 4'd9 && !sfn_lsb);
    dem_ok = demap_flag | demap_ready;
    nrs_ok = nrs_flag | nrs_gen_ready;
  end
`ifdef CH_EST_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd;
  // wd equals the number of cycles already spent in WAIT_RDY/RUN for this run
  assign tmo = (state == WAIT_RDY || state == RUN) && wd == TIMEOUT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wd          <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd          <= (state == WAIT_RDY || state == RUN) ? wd + 1'b1 : '0;
      err_timeout <= tmo | (err_timeout & ~err_clr);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{TIMEOUT_W, TIMEOUT_CYC};
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sf_idx        <= 4'd9;
      core_v_shift  <= 3'd0;
      core_start    <= 1'b0;
      est_ack_demap <= 1'b0;
      est_ack_nrs   <= 1'b0;
      sf_skip       <= 1'b0;
      busy          <= 1'b0;
      err_overrun   <= 1'b0;
      demap_flag    <= 1'b0;
      nrs_flag      <= 1'b0;
    end else begin
      core_start    <= 1'b0;
      est_ack_demap <= 1'b0;
      est_ack_nrs   <= 1'b0;
      sf_skip       <= 1'b0;
      if (sf_start) sf_idx <= nidx;
      err_overrun <= (sf_start && state != IDLE) | (err_overrun & ~err_clr);
      case (state)
        IDLE: if (sf_start) begin
          if (skip) sf_skip <= 1'b1;
          else begin
            core_v_shift <= v_shift;
            demap_flag   <= 1'b0;
            nrs_flag     <= 1'b0;
            busy         <= 1'b1;
            state        <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          demap_flag <= dem_ok;
          nrs_flag   <= nrs_ok;
          if (tmo) begin
            est_ack_demap <= 1'b1;
            est_ack_nrs   <= 1'b1;
            state         <= ACK;
          end else if (dem_ok && nrs_ok) begin
            core_start <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: if (tmo || core_done) begin
          est_ack_demap <= 1'b1;
          est_ack_nrs   <= 1'b1;
          state         <= ACK;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ch_est_sched.sv
// tb_ch_est_sched: randomized subframe traffic checked against timing-rule predictions.
module tb_ch_est_sched;
  logic       clk = 0, rst = 1, sf_start = 0, sfn_lsb = 0, demap_ready = 0, nrs_gen_ready = 0;
  logic       core_done = 0, err_clr = 0;
  logic [2:0] v_shift = 0;
  logic       core_start, est_ack_demap, est_ack_nrs, sf_skip, busy, err_overrun, err_timeout;
  logic [2:0] core_v_shift;
  logic [3:0] sf_idx;
  int         n_checks = 0, n_fail = 0;
  int         exp_idx;
  logic [2:0] exp_vs;
  bit         exp_start, exp_ack, exp_skip, exp_busy, exp_ov, exp_to;

  ch_est_sched #(.TIMEOUT_W(12), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .sf_start(sf_start), .sfn_lsb(sfn_lsb), .v_shift(v_shift),
    .demap_ready(demap_ready), .nrs_gen_ready(nrs_gen_ready), .core_done(core_done),
    .err_clr(err_clr), .core_start(core_start), .core_v_shift(core_v_shift),
    .est_ack_demap(est_ack_demap), .est_ack_nrs(est_ack_nrs), .sf_idx(sf_idx),
    .sf_skip(sf_skip), .busy(busy), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all;
    check("sf_idx", 32'(sf_idx), exp_idx);
    check("core_v_shift", 32'(core_v_shift), 32'(exp_vs));
    check("core_start", 32'(core_start), 32'(exp_start));
    check("ack_demap", 32'(est_ack_demap), 32'(exp_ack));
    check("ack_nrs", 32'(est_ack_nrs), 32'(exp_ack));
    check("sf_skip", 32'(sf_skip), 32'(exp_skip));
    check("busy", 32'(busy), 32'(exp_busy));
    check("err_overrun", 32'(err_overrun), 32'(exp_ov));
    check("err_timeout", 32'(err_timeout), 32'(exp_to));
  endtask

  task automatic step(input bit ov_set, input bit to_set);
    exp_ov = ov_set | (exp_ov & !err_clr);
    exp_to = to_set | (exp_to & !err_clr);
    if (sf_start) exp_idx = (exp_idx + 1) % 10;
    @(posedge clk);
    #1;
    check_all;
  endtask

  task automatic do_reset;
    rst = 1; sf_start = 0; demap_ready = 0; nrs_gen_ready = 0; core_done = 0; err_clr = 0;
    @(posedge clk);
    #1;
    rst = 0;
    exp_idx = 9; exp_vs = 0;
    {exp_start, exp_ack, exp_skip, exp_busy, exp_ov, exp_to} = '0;
    check_all;
  endtask

  task automatic idle(input int n, input bit fclr);
    for (int i = 0; i < n; i++) begin
      sf_start = 0; v_shift = 3'($urandom);
      demap_ready = 1'($urandom); nrs_gen_ready = 1'($urandom); core_done = 1'($urandom);
      err_clr = fclr ? 1'b1 : ($urandom % 4 == 0);
      {exp_start, exp_ack, exp_skip, exp_busy} = '0;
      step(0, 0);
    end
  endtask

  // One subframe: sf_start at cycle 0, readies at dn/dd (pulsed or held), core_done dl cycles
  // after launch, optional extra sf_start at cycle ov (with err_clr = ovclr in that cycle).
  task automatic run_sf(input bit lsb, input logic [2:0] vs, input int dn, input int dd,
                        input bit hold, input int dl, input int ov, input bit ovclr);
    int  l, a, ni;
    bit  sk;
    ni = (exp_idx + 1) % 10;
    sk = ni == 0 || ni == 5 || (ni == 9 && !lsb);
    sf_start = 1; sfn_lsb = lsb; v_shift = vs;
    demap_ready = 1'($urandom); nrs_gen_ready = 1'($urandom); core_done = 1'($urandom);
    err_clr = ($urandom % 4 == 0);
    exp_skip = sk; exp_busy = !sk; exp_start = 0; exp_ack = 0;
    if (!sk) exp_vs = vs;
    step(0, 0);
    sf_start = 0; sfn_lsb = 1'($urandom);
    if (sk) begin
      idle(1, 0);
      return;
    end
    l = (dn > dd ? dn : dd) + 1;
    a = l + dl + 1;
    for (int t = 1; t <= a; t++) begin
      sf_start = (t == ov); v_shift = 3'($urandom);
      if (t < l) begin
        nrs_gen_ready = hold ? (t >= dn) : (t == dn);
        demap_ready   = hold ? (t >= dd) : (t == dd);
        core_done     = 1'($urandom);
      end else begin
        nrs_gen_ready = 1'($urandom); demap_ready = 1'($urandom);
        core_done = (t == l + dl) ? 1'b1 : (t > l + dl ? 1'($urandom) : 1'b0);
      end
      err_clr = (t == ov) ? ovclr : ($urandom % 6 == 0);
      exp_start = (t + 1 == l); exp_ack = (t + 1 == a); exp_busy = (t + 1 <= a); exp_skip = 0;
      step(t == ov, 0);
    end
    sf_start = 0;
  endtask

  task automatic run_live(input logic [2:0] vs, input int dn, input int dd, input bit hold,
                          input int dl, input int ov, input bit ovclr);
    while (exp_idx == 9 || exp_idx == 4) run_sf(1, 3'd0, 1, 1, 1, 0, 0, 0);
    run_sf(1, vs, dn, dd, hold, dl, ov, ovclr);
  endtask

  initial begin
    int dn, dd, dl, l, a, ov;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      run_sf(0, 3'($urandom), 1, 1, 1, $urandom_range(0, 3), 0, 0);
      idle(1, 0);
    end
    for (int i = 0; i < 10; i++) begin
      run_sf(1, 3'($urandom), 1, 1, 1, $urandom_range(0, 3), 0, 0);
      idle(1, 0);
    end
    run_live(3'd4, 3, 7, 0, 2, 0, 0);
    idle(1, 0);
    run_live(3'd1, 4, 4, 0, 1, 0, 0);
    idle(1, 0);
    run_live(3'd5, 2, 2, 0, 3, 0, 0);
    idle(1, 0);
    run_live(3'd6, 2, 2, 0, 3, 4, 0);
    run_live(3'd3, 2, 2, 0, 3, 4, 1);
    idle(1, 1);
    run_live(3'd2, 1, 2, 1, 0, 4, 0);
    for (int i = 0; i < 60; i++) begin
      dn = $urandom_range(1, 12); dd = $urandom_range(1, 12); dl = $urandom_range(0, 5);
      l = (dn > dd ? dn : dd) + 1; a = l + dl + 1;
      ov = ($urandom % 4 == 0) ? $urandom_range(1, a) : 0;
      run_sf(1'($urandom), 3'($urandom), dn, dd, 1'($urandom), dl, ov, 1'($urandom));
      idle($urandom_range(0, 2), 0);
    end
    run_live(3'd7, 1, 1, 1, 6, 3, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_idx = 9; exp_vs = 0;
    {exp_start, exp_ack, exp_skip, exp_busy, exp_ov, exp_to} = '0;
    check_all;
    idle(2, 0);
    while (exp_idx == 9 || exp_idx == 4) run_sf(1, 3'd0, 1, 1, 1, 0, 0, 0);
    sf_start = 1; sfn_lsb = 1; v_shift = 3'd3;
    demap_ready = 0; nrs_gen_ready = 0; core_done = 0; err_clr = 0;
    exp_busy = 1; exp_vs = 3'd3; {exp_start, exp_ack, exp_skip} = '0;
    step(0, 0);
    sf_start = 0;
`ifdef CH_EST_SCHED_TIMEOUT_EN
    for (int t = 1; t <= 21; t++) begin
      exp_start = 0; exp_ack = (t + 1 == 21); exp_busy = (t + 1 <= 21);
      step(0, t == 20);
    end
`else
    for (int t = 1; t <= 100; t++) begin
      exp_start = 0; exp_ack = 0; exp_busy = 1;
      step(0, 0);
    end
    do_reset;
`endif
    idle(3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ch_est_sched.md
# ch_est_sched

Subframe-level scheduler for the NB-IoT channel-estimation core. It tracks the subframe index, skips subframes that carry no NRS-based data (NPBCH, NPSS, NSSS), and waits for both the demapper and the NRS generator to be ready. It then launches one estimation run, latching `v_shift` for it, and acknowledges both upstream blocks when the core finishes. It sits between the subframe timing unit, the demapper/NRS generator handshakes and the start/done pins of the channel-estimation core.

## Interface
- `TIMEOUT_W`, 12: width of the watchdog counter.
- `TIMEOUT_CYC`, 3000: watchdog limit in cycles; must be < 2^`TIMEOUT_W`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sf_start` in 1: one-cycle pulse at each subframe boundary.
- `sfn_lsb` in 1: LSB of the system frame number; sampled with `sf_start`.
- `v_shift` in 3: NRS frequency shift; sampled with `sf_start`.
- `demap_ready` in 1: demapper has the subframe grid available.
- `nrs_gen_ready` in 1: NRS generator has its sequence available.
- `core_done` in 1: one-cycle pulse from the core after its last `valid_eqlz`.
- `err_clr` in 1: clears the sticky error flags.
- `core_start` out 1: one-cycle launch pulse to the core.
- `core_v_shift` out 3: registered `v_shift` for the current run.
- `est_ack_demap` out 1: one-cycle acknowledge to the demapper.
- `est_ack_nrs` out 1: one-cycle acknowledge to the NRS generator.
- `sf_idx` out 4: current subframe index, 0..9.
- `sf_skip` out 1: one-cycle pulse when a subframe is skipped.
- `busy` out 1: high in every state except IDLE.
- `err_overrun` out 1: sticky; set when `sf_start` arrives while busy.
- `err_timeout` out 1: sticky; set when the watchdog fires (see Configuration).

## Operation
- States: IDLE, WAIT_RDY, RUN, ACK.
- Reset values:
  - state = IDLE.
  - `sf_idx` = 9, so the first `sf_start` yields 0.
  - `core_v_shift` = 0.
  - All pulse outputs, `busy` and both error flags = 0.
  - Internal ready flags and watchdog counter = 0.
- `sf_idx` update: on every `sf_start`, in any state, `sf_idx` increments; 9 wraps to 0.
- Skip rule: the new index is skipped if it is 0, 5, or 9 with `sfn_lsb` = 0.
- IDLE with `sf_start`:
  - Skipped subframe: pulse `sf_skip` next cycle; stay in IDLE.
  - Otherwise: latch `v_shift` into `core_v_shift`; clear both ready flags; go to WAIT_RDY.
- WAIT_RDY:
  - Each ready input sets its own sticky flag, so the inputs may arrive in either order or in the same cycle.
  - A flag counts as set in the cycle its input is high.
  - When both are set: go to RUN with `core_start` = 1 in that first RUN cycle.
- RUN: on `core_done`, go to ACK; `est_ack_demap` and `est_ack_nrs` are both 1 in the ACK cycle.
- ACK: lasts one cycle, then IDLE.
- Ignored inputs:
  - `demap_ready` and `nrs_gen_ready` are ignored outside WAIT_RDY.
  - `core_done` is ignored outside RUN.
- `sf_start` while state ≠ IDLE (including the ACK cycle):
  - Sets `err_overrun` and advances `sf_idx`.
  - That subframe is dropped; the current run continues undisturbed.
  - `core_v_shift` is not updated.
- `err_clr` clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- Reset asserted mid-run: return to IDLE at the next edge. No ack or `core_start` is emitted.

## Timing
- `sf_start` at cycle N → WAIT_RDY at N+1.
- Both ready flags satisfied at cycle M → `core_start` at M+1.
- Minimum `sf_start`-to-`core_start` latency: 2 cycles, when both readies are already high at N+1.
- `core_done` at cycle K → acks at K+1 → IDLE and `busy` = 0 at K+2.
- Skipped subframe: `sf_skip` at N+1; `busy` stays 0.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro: `CH_EST_SCHED_TIMEOUT_EN`.
- Defined:
  - The watchdog counts cycles spent in WAIT_RDY and RUN, reset on entry to WAIT_RDY.
  - On reaching `TIMEOUT_CYC` − 1: set `err_timeout`, go to ACK, and pulse both acks to release upstream. No `core_start` is issued if firing in WAIT_RDY.
- Undefined: no counter is built, `err_timeout` is tied to 0, and WAIT_RDY and RUN wait indefinitely.

## Test plan
- Reset, then 10 `sf_start` pulses with `sfn_lsb` = 0 and both readies held high:
  - `sf_idx` steps 0..9.
  - `sf_skip` occurs at 0, 5 and 9.
  - 7 `core_start`s, each 2 cycles after its `sf_start`.
- `sf_idx` = 9 with `sfn_lsb` = 1 → run launched, no skip.
- Ready ordering in WAIT_RDY:
  - `nrs_gen_ready` at +3, `demap_ready` at +7 → `core_start` at +8.
  - Both readies in the same cycle → `core_start` in the next cycle.
- `v_shift` = 5 at `sf_start`, changed to 2 during RUN → `core_v_shift` stays 5.
  - `core_done` → both acks for exactly 1 cycle, then `busy` = 0.
- Error flags:
  - `sf_start` during RUN → `err_overrun` = 1, `sf_idx` advances, no second `core_start`.
  - `err_clr` → 0.
  - `err_clr` coinciding with a new overrun → stays 1.
- With the macro defined and `TIMEOUT_CYC` = 20, no readies → `err_timeout` at WAIT_RDY cycle 19, acks at cycle 20, no `core_start`.
  - Without the macro, the same stimulus keeps the scheduler in WAIT_RDY indefinitely.
